shot_sequencer: RTL and testbench

- Upstream controller for the shot-scoring datapath: turns the raw "score this" push-button into a single, validated, one-cycle fire request.
- Latches the shot coordinates and bomb type, owns the big-bomb inventory, and rejects illegal shots.
- Accumulates the per-shot hit count returned by the scoring stage into game totals, and declares game over.
- Sits between the board switches/KEY and the hit-scoring logic; its outputs drive the score-enable, coordinate, big and wrong inputs of that logic.

---
 rtl/battleship_pkg.sv | 30 +++
 rtl/shot_sequencer_key_conditioner.sv | 58 +++++
 rtl/shot_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_shot_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship shot-scoring path.
package battleship_pkg;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FIRE,
    RELEASE,
    DONE
  } seq_state_t;

  localparam int GRID_MIN         = 1;
  localparam int GRID_MAX         = 10;
  localparam int SHIP_SQUARES_DEF = 19;
  localparam int MAX_HIT          = 9;

  function automatic logic in_grid(input coord_t c);
    return (c >= 4'(GRID_MIN)) && (c <= 4'(GRID_MAX));
  endfunction

  // Row-major square number, 0..99 for on-grid coordinates.
  function automatic logic [6:0] square_index(input coord_t x, input coord_t y);
    logic [6:0] row;
    row = {3'b000, y} - 7'd1;
    return 7'(row * 7'd10) + {3'b000, x} - 7'd1;
  endfunction

endpackage

// File: rtl/shot_sequencer_key_conditioner.sv
// key_conditioner: synchronizes and debounces the active-low push-button,
// producing a debounced pressed level and a one-cycle press pulse.
module key_conditioner
  import battleship_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_L,
  input  logic key_n,
  output logic press,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          raw_pressed, mismatch, expire;

  always_comb begin
    raw_pressed = ~sync2_q;
    mismatch    = raw_pressed != level_q;
    expire      = mismatch && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d       = '0;
    level_d     = level_q;
    press_d     = 1'b0;
    if (expire) begin
      level_d = raw_pressed;
      press_d = raw_pressed;
    end else if (mismatch) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer flops reset to the released (high) key level.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
  assign level = level_q;

endmodule

// File: rtl/shot_sequencer.sv
// shot_sequencer: validates key presses into one-cycle fire strobes and keeps
// game totals. Optional repeat-shot map: SHOT_SEQUENCER_REPEAT_CHECK_EN.
module shot_sequencer
  import battleship_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BIG_BOMBS       = 2,
  parameter int SHIP_SQUARES    = SHIP_SQUARES_DEF
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       score_key_n,
  input  logic       new_game,
  input  logic [3:0] x_sw,
  input  logic [3:0] y_sw,
  input  logic       big_sw,
  input  logic [3:0] num_hit,
  output logic       score_this,
  output logic [3:0] x_lat,
  output logic [3:0] y_lat,
  output logic       big_lat,
  output logic [1:0] big_left,
  output logic       wrong,
  output logic [6:0] shots,
  output logic [4:0] total_hits,
  output logic       game_over
);

  localparam logic [1:0] BIG_INIT = 2'(BIG_BOMBS);
  localparam logic [4:0] SHIPS    = 5'(SHIP_SQUARES);

  logic press, key_level;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clock   (clock),
    .reset_L (reset_L),
    .key_n   (score_key_n),
    .press   (press),
    .level   (key_level)
  );

  seq_state_t state_q, state_d;
  coord_t     x_lat_q, x_lat_d, y_lat_q, y_lat_d;
  logic       big_lat_q, big_lat_d;
  logic       score_this_q, score_this_d;
  logic [1:0] big_left_q, big_left_d;
  logic       wrong_q, wrong_d;
  logic [6:0] shots_q, shots_d;
  logic [4:0] total_q, total_d;
  logic       over_q, over_d;
  logic [3:0] hit_clamped;
  logic [5:0] sum;
  logic [4:0] new_total;
  logic       shot_ok;
`ifdef SHOT_SEQUENCER_REPEAT_CHECK_EN
  logic [99:0] map_q, map_d;
`endif

  always_comb begin
    hit_clamped = (num_hit > 4'(MAX_HIT)) ? 4'(MAX_HIT) : num_hit;
    sum         = {1'b0, total_q} + {2'b00, hit_clamped};
    new_total   = (sum >= 6'(SHIP_SQUARES)) ? SHIPS : sum[4:0];
    shot_ok     = in_grid(x_lat_q) && in_grid(y_lat_q) &&
                  !(big_lat_q && (big_left_q == 2'd0));
`ifdef SHOT_SEQUENCER_REPEAT_CHECK_EN
    // Only the centre square is tracked, so big bombs bypass the map.
    if (shot_ok && !big_lat_q && map_q[square_index(x_lat_q, y_lat_q)])
      shot_ok = 1'b0;
    map_d = map_q;
`endif

    state_d      = state_q;
    x_lat_d      = x_lat_q;
    y_lat_d      = y_lat_q;
    big_lat_d    = big_lat_q;
    score_this_d = 1'b0;
    big_left_d   = big_left_q;
    wrong_d      = wrong_q;
    shots_d      = shots_q;
    total_d      = total_q;
    over_d       = over_q;

    case (state_q)
      IDLE: begin
        if (press) begin
          x_lat_d   = x_sw;
          y_lat_d   = y_sw;
          big_lat_d = big_sw;
          wrong_d   = 1'b0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (shot_ok) begin
          score_this_d = 1'b1;
          state_d      = FIRE;
        end else begin
          wrong_d = 1'b1;
          state_d = RELEASE;
        end
      end
      FIRE: begin
        total_d = new_total;
        shots_d = (shots_q == 7'd127) ? shots_q : shots_q + 7'd1;
        if (big_lat_q) big_left_d = big_left_q - 2'd1;
`ifdef SHOT_SEQUENCER_REPEAT_CHECK_EN
        map_d[square_index(x_lat_q, y_lat_q)] = 1'b1;
`endif
        if (new_total == SHIPS) begin
          over_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!key_level) state_d = IDLE;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Restart lands in RELEASE so a key still held cannot fire.
    if (new_game) begin
      state_d      = RELEASE;
      x_lat_d      = '0;
      y_lat_d      = '0;
      big_lat_d    = 1'b0;
      score_this_d = 1'b0;
      big_left_d   = BIG_INIT;
      wrong_d      = 1'b0;
      shots_d      = '0;
      total_d      = '0;
      over_d       = 1'b0;
`ifdef SHOT_SEQUENCER_REPEAT_CHECK_EN
      map_d        = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      big_lat_q    <= 1'b0;
      score_this_q <= 1'b0;
      big_left_q   <= BIG_INIT;
      wrong_q      <= 1'b0;
      shots_q      <= '0;
      total_q      <= '0;
      over_q       <= 1'b0;
`ifdef SHOT_SEQUENCER_REPEAT_CHECK_EN
      map_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_lat_q      <= x_lat_d;
      y_lat_q      <= y_lat_d;
      big_lat_q    <= big_lat_d;
      score_this_q <= score_this_d;
      big_left_q   <= big_left_d;
      wrong_q      <= wrong_d;
      shots_q      <= shots_d;
      total_q      <= total_d;
      over_q       <= over_d;
`ifdef SHOT_SEQUENCER_REPEAT_CHECK_EN
      map_q        <= map_d;
`endif
    end
  end

  assign score_this = score_this_q;
  assign x_lat      = x_lat_q;
  assign y_lat      = y_lat_q;
  assign big_lat    = big_lat_q;
  assign big_left   = big_left_q;
  assign wrong      = wrong_q;
  assign shots      = shots_q;
  assign total_hits = total_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Testbench for shot_sequencer: directed scenarios plus randomized presses,
// checked by a scoreboard fed from a game-rules reference model.
module tb_shot_sequencer;

  localparam int DEB   = 4;
  localparam int BIG   = 2;
  localparam int SHIPS = 19;
  // Two synchronizer stages, DEB debounce cycles, then press -> CHECK -> FIRE.
  localparam int LATENCY = 2 + DEB + 2;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       score_key_n = 1'b1;
  logic       new_game = 1'b0;
  logic [3:0] x_sw = '0, y_sw = '0, num_hit = '0;
  logic       big_sw = 1'b0;
  logic       score_this, big_lat, wrong, game_over;
  logic [3:0] x_lat, y_lat;
  logic [1:0] big_left;
  logic [6:0] shots;
  logic [4:0] total_hits;

  shot_sequencer #(.DEBOUNCE_CYCLES(DEB), .BIG_BOMBS(BIG), .SHIP_SQUARES(SHIPS)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .score_key_n (score_key_n),
    .new_game    (new_game),
    .x_sw        (x_sw),
    .y_sw        (y_sw),
    .big_sw      (big_sw),
    .num_hit     (num_hit),
    .score_this  (score_this),
    .x_lat       (x_lat),
    .y_lat       (y_lat),
    .big_lat     (big_lat),
    .big_left    (big_left),
    .wrong       (wrong),
    .shots       (shots),
    .total_hits  (total_hits),
    .game_over   (game_over)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       big;
    int         shots;
    int         total;
  } fire_t;

  fire_t sbq[$];
  fire_t monEntry;
  int compared = 0, mismatched = 0;
  int strobes = 0, expStrobes = 0, strobeCycle = -1;

  // Reference model of the game rules
  int         mShots, mTotal, mBigLeft;
  bit         mWrong, mOver, mBig;
  logic [3:0] mX, mY;
  bit         mMap[100];

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic modelClear();
    mShots = 0; mTotal = 0; mBigLeft = BIG;
    mWrong = 0; mOver = 0; mBig = 0; mX = 0; mY = 0;
    foreach (mMap[i]) mMap[i] = 0;
  endtask

  // Predicts one press; pushes the expected fire into the scoreboard.
  task automatic modelPress(input int x, input int y, input bit big, input int hit,
                            output bit fire);
    bit ok;
    fire = 0;
    if (mOver) return;
    mX = 4'(x); mY = 4'(y); mBig = big; mWrong = 0;
    ok = (x >= 1) && (x <= 10) && (y >= 1) && (y <= 10) && !(big && mBigLeft == 0);
`ifdef SHOT_SEQUENCER_REPEAT_CHECK_EN
    if (ok && !big && mMap[(y - 1) * 10 + (x - 1)]) ok = 0;
`endif
    if (!ok) begin
      mWrong = 1;
      return;
    end
    fire = 1;
    mShots = (mShots + 1 > 127) ? 127 : mShots + 1;
    mTotal = mTotal + ((hit > 9) ? 9 : hit);
    if (mTotal > SHIPS) mTotal = SHIPS;
    if (big) mBigLeft--;
    mMap[(y - 1) * 10 + (x - 1)] = 1;
    if (mTotal == SHIPS) mOver = 1;
    sbq.push_back('{x: 4'(x), y: 4'(y), big: big, shots: mShots, total: mTotal});
    expStrobes++;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_wrong"},     wrong,      mWrong);
    checkOutput({tag, "_shots"},     shots,      mShots);
    checkOutput({tag, "_total"},     total_hits, mTotal);
    checkOutput({tag, "_big_left"},  big_left,   mBigLeft);
    checkOutput({tag, "_game_over"}, game_over,  mOver);
    checkOutput({tag, "_x_lat"},     x_lat,      mX);
    checkOutput({tag, "_y_lat"},     y_lat,      mY);
    checkOutput({tag, "_big_lat"},   big_lat,    mBig);
  endtask

  // Monitor: every strobe must match the oldest predicted fire, last one
  // cycle, and show the updated totals on the following cycle.
  always @(negedge clock) begin
    if (reset_L && score_this) begin
      strobes++;
      strobeCycle = cyc;
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_strobe: got strobe at cycle %0d, want none", cyc);
      end else begin
        monEntry = sbq.pop_front();
        checkOutput("strobe_x",   x_lat,   monEntry.x);
        checkOutput("strobe_y",   y_lat,   monEntry.y);
        checkOutput("strobe_big", big_lat, monEntry.big);
        @(negedge clock);
        checkOutput("strobe_width",     score_this, 0);
        checkOutput("shots_after_fire", shots,      monEntry.shots);
        checkOutput("total_after_fire", total_hits, monEntry.total);
      end
    end
  end

  // Drives one key press (optionally bouncy) and checks the settled outputs.
  task automatic applyStimulus(input int x, input int y, input bit big, input int hit,
                               input int hold, input bit bounce, input string tag);
    bit fire;
    int stable;
    @(negedge clock);
    x_sw = 4'(x); y_sw = 4'(y); big_sw = big; num_hit = 4'(hit);
    modelPress(x, y, big, hit, fire);
    if (bounce)
      for (int i = 0; i < 5; i++) begin
        score_key_n = 1'b0; repeat (2) @(negedge clock);
        score_key_n = 1'b1; repeat (2) @(negedge clock);
      end
    score_key_n = 1'b0;
    stable = cyc;
    repeat (hold) @(negedge clock);
    score_key_n = 1'b1;
    repeat (12) @(negedge clock);
    if (fire) checkOutput({tag, "_latency"}, strobeCycle - stable, LATENCY);
    checkAll(tag);
  endtask

  task automatic doNewGame(input string tag);
    @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    modelClear();
    checkAll(tag);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit dummy;
    int rx, ry, rh;
    bit rb;
    modelClear();
    repeat (3) @(negedge clock);
    checkOutput("reset_score_this", score_this, 0);
    checkAll("reset");
    reset_L = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] bounce then hold");
    applyStimulus(6, 7, 0, 2, 12, 1, "bounce");

    $display("[TB] illegal then legal coordinates");
    applyStimulus(0, 5, 0, 1, 12, 0, "bad_x");
    applyStimulus(3, 2, 0, 1, 12, 0, "good_after_bad");
    applyStimulus(11, 4, 0, 1, 12, 0, "bad_x_hi");
    applyStimulus(4, 0, 0, 1, 12, 0, "bad_y");

    $display("[TB] big bomb inventory");
    doNewGame("ng1");
    applyStimulus(2, 5, 1, 4, 12, 0, "big1");
    applyStimulus(7, 8, 1, 4, 12, 0, "big2");
    applyStimulus(9, 1, 1, 4, 12, 0, "big3");

    $display("[TB] held key");
    applyStimulus(10, 10, 0, 0, 50, 0, "held");

    $display("[TB] saturation and game over");
    doNewGame("ng2");
    applyStimulus(1, 1, 0, 9, 12, 0, "sat1");
    applyStimulus(2, 2, 0, 9, 12, 0, "sat2");
    applyStimulus(3, 3, 0, 9, 12, 0, "sat3");
    applyStimulus(5, 5, 0, 3, 12, 0, "after_over");
    doNewGame("ng3");

    $display("[TB] repeat square");
    applyStimulus(4, 4, 0, 1, 12, 0, "rep1");
    applyStimulus(4, 4, 0, 1, 12, 0, "rep2");
    applyStimulus(4, 4, 1, 1, 12, 0, "rep_big");

    $display("[TB] reset during CHECK");
    @(negedge clock);
    x_sw = 4'd5; y_sw = 4'd5; big_sw = 1'b0; num_hit = 4'd2;
    score_key_n = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset_L = 1'b0;
    score_key_n = 1'b1;
    #1;
    checkOutput("reset_drop_strobe", score_this, 0);
    modelClear();
    repeat (3) @(negedge clock);
    checkAll("mid_reset");
    reset_L = 1'b1;
    repeat (12) @(negedge clock);
    checkAll("post_reset");

    $display("[TB] random presses");
    for (int i = 0; i < 24; i++) begin
      if (mOver || ($urandom_range(0, 7) == 0)) doNewGame("rnd_ng");
      rx = $urandom_range(0, 11);
      ry = $urandom_range(0, 11);
      rb = ($urandom_range(0, 3) == 0);
      rh = $urandom_range(0, 15);
      applyStimulus(rx, ry, rb, rh, $urandom_range(10, 20), $urandom_range(0, 1), "rnd");
    end
    dummy = 0;

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    checkOutput("strobe_count", strobes, expStrobes);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
